// File: rtl/fp_sort_pkg.sv
// Shared types and helpers for the sorted float loader and its companion blocks.
// fp_key maps an IEEE-754 single to an unsigned key whose natural order matches numeric order.
package fp_sort_pkg;

    localparam int FP_W          = 32;
    localparam int DEFAULT_DEPTH = 24;
    localparam int DEFAULT_AW    = 6;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Negative values flip completely so larger magnitudes order lower; positives just flip the sign bit.
    function automatic logic [FP_W-1:0] fp_key(input logic [FP_W-1:0] x);
        return x[FP_W-1] ? ~x : (x ^ 32'h8000_0000);
    endfunction

endpackage

// File: rtl/fp_key_cmp.sv
// Combinational float comparator: a_gt_b is high when key(a) > key(b), so -0 < +0
// and NaNs order outside the infinities.
module fp_key_cmp
    import fp_sort_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic            a_gt_b
);

    assign a_gt_b = fp_key(a) > fp_key(b);

endmodule

// File: rtl/fp_sorted_loader.sv
// Insertion-sorts incoming floats into an ascending register table and mirrors
// every table write onto a registered memory write port feeding the search memory.
module fp_sorted_loader
    import fp_sort_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            in_valid,
    input  logic [31:0]     in_data,
    output logic            in_ready,
    output logic            busy,
    output logic [AW-1:0]   count,
    output logic            full,
    output logic            overflow,
    output logic            table_valid,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [31:0]     mem_wdata
);

    state_t            state_q, state_d;
    logic [AW-1:0]     p_q, p_d;
    logic [FP_W-1:0]   v_q, v_d;
    logic [AW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              mem_we_q, mem_we_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [FP_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [FP_W-1:0]   tab_q [DEPTH];
    logic [FP_W-1:0]   tab_d [DEPTH];

    logic              wr_en;
    logic [FP_W-1:0]   wr_data;
    logic [FP_W-1:0]   prev_val;
    logic              prev_gt;
    logic              full_w;

    assign full_w = (count_q == AW'(DEPTH));

    always_comb begin
        prev_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (AW'(i) == p_q - AW'(1)) begin
                prev_val = tab_q[i];
            end
        end
    end

    fp_key_cmp u_cmp (
        .a      (prev_val),
        .b      (v_q),
        .a_gt_b (prev_gt)
    );

    // Strict greater-than keeps equal keys in arrival order.
    always_comb begin
        state_d    = state_q;
        p_d        = p_q;
        v_d        = v_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        wr_data    = v_q;
        if (clear) begin
            state_d    = IDLE;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (full_w) begin
                            overflow_d = 1'b1;
                        end else begin
                            v_d     = in_data;
                            p_d     = count_q;
                            state_d = SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    wr_en = 1'b1;
                    if ((p_q != '0) && prev_gt) begin
                        wr_data = prev_val;
                        p_d     = p_q - AW'(1);
                    end else begin
                        wr_data = v_q;
                        count_d = count_q + AW'(1);
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        tab_d = tab_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && (AW'(i) == p_q)) begin
                tab_d[i] = wr_data;
            end
        end
    end

    assign mem_we_d    = wr_en;
    assign mem_addr_d  = wr_en ? p_q : mem_addr_q;
    assign mem_wdata_d = wr_en ? wr_data : mem_wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            p_q         <= '0;
            v_q         <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            v_q         <= v_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Entries past count are don't-care, so the table itself needs no reset.
    always_ff @(posedge clk) begin
        tab_q <= tab_d;
    end

    assign in_ready    = (state_q == IDLE) && !full_w && !clear;
    assign busy        = (state_q == SHIFT) || mem_we_q;
    assign count       = count_q;
    assign full        = full_w;
    assign overflow    = overflow_q;
    assign table_valid = !busy && !mem_we_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_fp_sorted_loader.sv
// Directed bench for fp_sorted_loader: inserts hand-picked floats and checks the
// mirrored write stream, status flags, clear and asynchronous reset behaviour.
module tb_fp_sorted_loader;

    localparam int DEPTH = 24;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          in_valid;
    logic [31:0]   in_data;
    logic          in_ready;
    logic          busy;
    logic [AW-1:0] count;
    logic          full;
    logic          overflow;
    logic          table_valid;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;

    int            checks   = 0;
    int            failures = 0;
    logic [31:0]   shadow [64];
    int            logAddr[$];
    logic [31:0]   logData[$];
    logic [31:0]   model[$];
    logic [31:0]   fillVal;
    int            base;
    int            lowCycles;
    int            pos;

    fp_sorted_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .busy        (busy),
        .count       (count),
        .full        (full),
        .overflow    (overflow),
        .table_valid (table_valid),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata)
    );

    always #5 clk = ~clk;

    // Record every mirror write into a shadow memory and an ordered log.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            shadow[mem_addr] = mem_wdata;
            logAddr.push_back(int'(mem_addr));
            logData.push_back(mem_wdata);
        end
    end

    function automatic logic [31:0] keyOf(input logic [31:0] x);
        return x[31] ? ~x : (x ^ 32'h8000_0000);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 1);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_count"}, 32'(count), 0);
        checkOutput({tag, "_full"}, 32'(full), 0);
        checkOutput({tag, "_overflow"}, 32'(overflow), 0);
        checkOutput({tag, "_table_valid"}, 32'(table_valid), 1);
        checkOutput({tag, "_mem_we"}, 32'(mem_we), 0);
        checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    task automatic waitIdle();
        int n = 0;
        while (table_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_wait", 32'(table_valid), 1);
    endtask

    task automatic applyStimulus(input logic [31:0] val, output int lowCnt);
        int n = 0;
        while (in_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_wait", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = val;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lowCnt   = 0;
        while (in_ready !== 1'b1 && lowCnt < 300) begin
            lowCnt++;
            @(negedge clk);
        end
        waitIdle();
    endtask

    task automatic pulseClear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkReset("reset");

        // Ascending inserts land without shifting.
        base = logAddr.size();
        applyStimulus(32'h4010_0000, lowCycles);
        checkOutput("asc1_writes", 32'(logAddr.size() - base), 1);
        checkOutput("asc1_addr", 32'(logAddr[base]), 0);
        checkOutput("asc1_data", logData[base], 32'h4010_0000);
        base = logAddr.size();
        applyStimulus(32'h4114_0000, lowCycles);
        checkOutput("asc2_writes", 32'(logAddr.size() - base), 1);
        checkOutput("asc2_addr", 32'(logAddr[base]), 1);
        checkOutput("asc2_data", logData[base], 32'h4114_0000);
        checkOutput("asc_count", 32'(count), 2);

        // Prepend -1.5 shifts both existing entries up.
        base = logAddr.size();
        applyStimulus(32'hBFC0_0000, lowCycles);
        checkOutput("pre_writes", 32'(logAddr.size() - base), 3);
        checkOutput("pre_addr0", 32'(logAddr[base]), 2);
        checkOutput("pre_data0", logData[base], 32'h4114_0000);
        checkOutput("pre_addr1", 32'(logAddr[base+1]), 1);
        checkOutput("pre_data1", logData[base+1], 32'h4010_0000);
        checkOutput("pre_addr2", 32'(logAddr[base+2]), 0);
        checkOutput("pre_data2", logData[base+2], 32'hBFC0_0000);
        checkOutput("pre_ready_low", 32'(lowCycles), 3);
        checkOutput("pre_count", 32'(count), 3);

        // Signed zeros and ties.
        pulseClear();
        checkOutput("clr_count", 32'(count), 0);
        applyStimulus(32'h0000_0000, lowCycles);
        base = logAddr.size();
        applyStimulus(32'h8000_0000, lowCycles);
        checkOutput("negz_writes", 32'(logAddr.size() - base), 2);
        checkOutput("negz_addr_last", 32'(logAddr[base+1]), 0);
        base = logAddr.size();
        applyStimulus(32'h0000_0000, lowCycles);
        checkOutput("tie_writes", 32'(logAddr.size() - base), 1);
        checkOutput("tie_addr", 32'(logAddr[base]), 2);
        checkOutput("tie_data", logData[base], 32'h0000_0000);
        checkOutput("zero_mem0", shadow[0], 32'h8000_0000);
        checkOutput("zero_mem1", shadow[1], 32'h0000_0000);
        checkOutput("zero_mem2", shadow[2], 32'h0000_0000);

        // Fill to capacity against a reference insertion model.
        pulseClear();
        model.delete();
        for (int i = 0; i < DEPTH; i++) begin
            fillVal = {1'(i % 2), 8'(120 + (i * 7) % 15), 23'(i * 40503)};
            applyStimulus(fillVal, lowCycles);
            pos = model.size();
            while (pos > 0 && keyOf(model[pos-1]) > keyOf(fillVal)) pos--;
            model.insert(pos, fillVal);
        end
        checkOutput("fill_count", 32'(count), 24);
        checkOutput("fill_full", 32'(full), 1);
        checkOutput("fill_in_ready", 32'(in_ready), 0);
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput($sformatf("fill_mem%0d", i), shadow[i], model[i]);
        end

        // Offer while full: dropped and flagged.
        base = logAddr.size();
        in_valid = 1'b1;
        in_data  = 32'h4780_0820;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("ovf_flag", 32'(overflow), 1);
        repeat (3) @(negedge clk);
        checkOutput("ovf_count", 32'(count), 24);
        checkOutput("ovf_writes", 32'(logAddr.size() - base), 0);
        checkOutput("ovf_sticky", 32'(overflow), 1);

        // Clear one cycle into a shift suppresses the pending mirror pulse.
        pulseClear();
        checkOutput("clr2_overflow", 32'(overflow), 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(32'h4000_0000 + 32'(i << 20), lowCycles);
        end
        checkOutput("ten_count", 32'(count), 10);
        in_valid = 1'b1;
        in_data  = 32'hC0A0_0000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("mid_busy", 32'(busy), 1);
        @(negedge clk);
        checkOutput("mid_we_pending", 32'(mem_we), 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checkOutput("mid_clr_count", 32'(count), 0);
        checkOutput("mid_clr_busy", 32'(busy), 0);
        checkOutput("mid_clr_we", 32'(mem_we), 0);
        checkOutput("mid_clr_overflow", 32'(overflow), 0);
        @(negedge clk);
        checkOutput("mid_clr_we_after", 32'(mem_we), 0);
        checkOutput("mid_clr_in_ready", 32'(in_ready), 1);

        // Asynchronous reset in the middle of a shift.
        applyStimulus(32'h3F80_0000, lowCycles);
        applyStimulus(32'h4000_0000, lowCycles);
        applyStimulus(32'h4040_0000, lowCycles);
        in_valid = 1'b1;
        in_data  = 32'hBF80_0000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        checkOutput("arst_pre_we", 32'(mem_we), 1);
        checkOutput("arst_pre_addr", 32'(mem_addr), 2);
        rst = 1'b1;
        #1;
        checkReset("arst");
        rst = 1'b0;
        @(negedge clk);
        checkReset("arst_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
